// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text-buffer write path.
// Character-grid geometry, console MMIO window and the write-grant source enum.
// Included by the console FIFO and the write arbiter.
package vga_text_pkg;

    localparam int          COLS         = 80;
    localparam int          ROWS         = 30;
    localparam int          NCHARS       = COLS * ROWS;
    localparam int          CHAR_W       = 12;
    localparam logic [7:0]  CHAR_SPACE   = 8'h20;
    localparam logic [31:0] CONSOLE_BASE = 32'hF000_0000;

    // Which source owns the display write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_CLEAR = 2'd1,
        SRC_CPU   = 2'd2,
        SRC_DBG   = 2'd3
    } src_e;

    // One character write: index into the grid plus the character itself.
    typedef struct packed {
        logic [CHAR_W-1:0] addr;
        logic [7:0]        data;
    } char_wr_t;

    // True when addr falls inside the 4 KiB window starting at base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:12] == base[31:12];
    endfunction

endpackage

// File: rtl/vga_text_fifo.sv
// Synchronous FIFO for buffered console character writes.
// Latency: a pushed entry is visible at the head (empty=0) one clk later.
// Backpressure: push while full is refused unless a pop happens the same cycle.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module vga_text_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/vga_text_write_arbiter.sv
// Shares the text-buffer write port between screen clear, CPU console FIFO and debugger.
// Latency: the cycle's winner appears on display_* one clk edge later.
// Backpressure: dbg_ready is a combinational grant; cpu_full flags a full console FIFO,
// further stores are dropped and latched in cpu_overflow.
// Ports: cpu_* MMIO store side, dbg_* valid/ready stream, clear_req/clear_busy, display_* write port.
module vga_text_write_arbiter #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          COLS         = vga_text_pkg::COLS,
    parameter int          ROWS         = vga_text_pkg::ROWS,
    parameter int          MAX_WAIT     = 8,
    parameter logic [31:0] CONSOLE_BASE = vga_text_pkg::CONSOLE_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_full,
    output logic        cpu_overflow,
    input  logic        dbg_valid,
    input  logic [11:0] dbg_addr,
    input  logic [7:0]  dbg_data,
    output logic        dbg_ready,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        display_wen,
    output logic [11:0] display_w_addr,
    output logic [7:0]  display_w_data
);

    import vga_text_pkg::*;

    localparam int          WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [11:0] NCHARS12 = 12'(COLS * ROWS);
    localparam logic [11:0] LAST_IDX = 12'(COLS * ROWS - 1);
    localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [11:0]   ptr_q, ptr_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          overflow_q, overflow_d;
    logic          wen_q, wen_d;
    logic [11:0]   waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;

    logic          in_clear, start_clear;
    logic          push_req, drop;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    char_wr_t      push_dat, pop_dat;
    src_e          src;

    vga_text_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(char_wr_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_dat),
        .pop   (fifo_pop),
        .rdata (pop_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Grant: clear engine, then a debugger that has waited its limit, then the FIFO,
    // then the debugger opportunistically. Nobody wins while rst is high.
    always_comb begin
        in_clear = (state_q == ST_CLEAR);
        push_req = cpu_wen && in_window(cpu_addr, CONSOLE_BASE) && (cpu_addr[11:0] < NCHARS12);
        push_dat = '{addr: cpu_addr[11:0], data: cpu_data[7:0]};

        src = SRC_NONE;
        if (rst) begin
            src = SRC_NONE;
        end else if (in_clear) begin
            src = SRC_CLEAR;
        end else if (dbg_valid && (wait_q == WAIT_MAX)) begin
            src = SRC_DBG;
        end else if (!fifo_empty) begin
            src = SRC_CPU;
        end else if (dbg_valid) begin
            src = SRC_DBG;
        end

        dbg_ready = (src == SRC_DBG);
        fifo_pop  = (src == SRC_CPU);
        drop      = push_req && fifo_full && !fifo_pop;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        start_clear = 1'b0;
        if (in_clear) begin
            if (ptr_q == LAST_IDX) begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end else begin
                ptr_d   = ptr_q + 12'd1;
            end
        end else if (clear_req) begin
            state_d     = ST_CLEAR;
            ptr_d       = '0;
            start_clear = 1'b1;
        end

        // A drop in the same cycle as clear entry still gets reported.
        overflow_d = overflow_q;
        if (start_clear) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        // The clear engine starves everyone equally, so starvation is not counted during it.
        wait_d = wait_q;
        if (!in_clear) begin
            if (dbg_valid && !dbg_ready) begin
                wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
            end else begin
                wait_d = '0;
            end
        end

        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (src)
            SRC_CLEAR: begin
                wen_d   = 1'b1;
                waddr_d = ptr_q;
                wdata_d = CHAR_SPACE;
            end
            SRC_CPU: begin
                wen_d   = 1'b1;
                waddr_d = pop_dat.addr;
                wdata_d = pop_dat.data;
            end
            SRC_DBG: begin
                wen_d   = 1'b1;
                waddr_d = dbg_addr;
                wdata_d = dbg_data;
            end
            default: begin
                wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            wait_q     <= '0;
            overflow_q <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
            overflow_q <= overflow_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign cpu_full       = fifo_full;
    assign cpu_overflow   = overflow_q;
    assign clear_busy     = in_clear;
    assign display_wen    = wen_q;
    assign display_w_addr = waddr_q;
    assign display_w_data = wdata_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, cpu_data[31:8], fifo_count};

endmodule

// File: tb/tb_vga_text_write_arbiter.sv
module tb_vga_text_write_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_WAIT   = 8;
    localparam int NCHARS     = 2400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wen;
    logic [31:0] cpu_addr, cpu_data;
    logic        cpu_full, cpu_overflow;
    logic        dbg_valid;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_data;
    logic        dbg_ready;
    logic        clear_req, clear_busy;
    logic        display_wen;
    logic [11:0] display_w_addr;
    logic [7:0]  display_w_data;

    vga_text_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_wen        (cpu_wen),
        .cpu_addr       (cpu_addr),
        .cpu_data       (cpu_data),
        .cpu_full       (cpu_full),
        .cpu_overflow   (cpu_overflow),
        .dbg_valid      (dbg_valid),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_ready      (dbg_ready),
        .clear_req      (clear_req),
        .clear_busy     (clear_busy),
        .display_wen    (display_wen),
        .display_w_addr (display_w_addr),
        .display_w_data (display_w_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: console queue, remaining clear cycles, starvation age.
    logic [19:0] q[$];
    int          clr_rem, clr_idx, wcnt;
    bit          ovf;
    bit          exp_wen;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;

    // Debugger stimulus state (held until handshake).
    bit          dv_cur;
    logic [11:0] da_cur;
    logic [7:0]  dd_cur;
    bit          last_hs;
    int          dbg_pct;

    task automatic model_reset();
        q.delete();
        clr_rem  = 0;
        clr_idx  = 0;
        wcnt     = 0;
        ovf      = 0;
        exp_wen  = 0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic cycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit dv, input logic [11:0] da, input logic [7:0] dd, input bit cr);
        bit busy, push_req, g_clr, g_cpu, g_dbg, drop;
        logic [19:0] ent;
        @(negedge clk);
        check_eq("display_wen", display_wen, exp_wen);
        check_eq("display_w_addr", display_w_addr, exp_addr);
        check_eq("display_w_data", display_w_data, exp_data);
        check_eq("cpu_full", cpu_full, q.size() == FIFO_DEPTH);
        check_eq("cpu_overflow", cpu_overflow, ovf);
        check_eq("clear_busy", clear_busy, clr_rem > 0);
        rst = r; cpu_wen = w; cpu_addr = a; cpu_data = d;
        dbg_valid = dv; dbg_addr = da; dbg_data = dd; clear_req = cr;
        #1;
        if (r) begin
            check_eq("dbg_ready_rst", dbg_ready, 1'b0);
            model_reset();
            last_hs = 0;
            return;
        end
        busy  = clr_rem > 0;
        g_clr = 0; g_cpu = 0; g_dbg = 0; drop = 0;
        push_req = w && (a[31:12] == 20'hF0000) && (int'(a[11:0]) < NCHARS);
        if (busy)                          g_clr = 1;
        else if (dv && wcnt == MAX_WAIT)   g_dbg = 1;
        else if (q.size() > 0)             g_cpu = 1;
        else if (dv)                       g_dbg = 1;
        check_eq("dbg_ready", dbg_ready, g_dbg);

        exp_wen = g_clr | g_cpu | g_dbg;
        if (g_clr) begin
            exp_addr = 12'(clr_idx);
            exp_data = 8'h20;
        end
        if (g_cpu) begin
            ent = q.pop_front();
            exp_addr = ent[19:8];
            exp_data = ent[7:0];
        end
        if (g_dbg) begin
            exp_addr = da;
            exp_data = dd;
        end
        if (push_req) begin
            if (q.size() < FIFO_DEPTH) q.push_back({a[11:0], d[7:0]});
            else drop = 1;
        end
        if (!busy) wcnt = (dv && !g_dbg) ? ((wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT) : 0;
        if (busy) begin
            clr_idx++;
            clr_rem--;
        end else if (cr) begin
            clr_rem = NCHARS;
            clr_idx = 0;
            ovf     = 0;
        end
        if (drop) ovf = 1;
        last_hs = g_dbg;
    endtask

    // Random CPU address: mostly valid console indices, some out-of-range, some outside window.
    task automatic gen_cpu(input int pct, output bit w, output logic [31:0] a, output logic [31:0] d);
        int sel;
        w   = ($urandom_range(0, 99) < pct);
        sel = $urandom_range(0, 9);
        d   = $urandom;
        if (sel <= 5)      a = 32'hF000_0000 | 32'($urandom_range(0, NCHARS - 1));
        else if (sel <= 7) a = 32'hF000_0000 | 32'($urandom_range(NCHARS, 4095));
        else if (sel == 8) a = $urandom & 32'h0FFF_FFFF;
        else               a = ($urandom_range(0, 1) == 1) ? 32'hF000_095F : 32'hF000_0000;
    endtask

    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit cr);
        if (!dv_cur || last_hs) begin
            dv_cur = ($urandom_range(0, 99) < dbg_pct);
            da_cur = 12'($urandom_range(0, NCHARS - 1));
            dd_cur = 8'($urandom);
        end
        cycle(r, w, a, d, dv_cur, da_cur, dd_cur, cr);
    endtask

    task automatic step_rand(input int pcpu, input bit r, input bit cr);
        bit w;
        logic [31:0] a, d;
        gen_cpu(pcpu, w, a, d);
        step(r, w, a, d, cr);
    endtask

    initial begin
        rst = 1'b1; cpu_wen = 0; cpu_addr = '0; cpu_data = '0;
        dbg_valid = 0; dbg_addr = '0; dbg_data = '0; clear_req = 0;
        dv_cur = 0; da_cur = '0; dd_cur = '0; last_hs = 0; dbg_pct = 30;
        model_reset();
        repeat (2) @(posedge clk);

        // Mixed traffic, then reset in the middle of it, then a full clear with stores during it.
        repeat (60) step_rand(50, 0, 0);
        repeat (2)  step_rand(50, 1, 0);
        step_rand(0, 0, 1);
        repeat (3) step_rand(0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'hF000_0010 + 32'(i), 32'h61 + 32'(i), 0);
        repeat (2420) step_rand(0, 0, 0);

        // Single console store with idle debugger; out-of-range index store.
        dbg_pct = 0;
        repeat (12) step_rand(0, 0, 0);
        step(0, 1, 32'hF000_0005, 32'h0000_0041, 0);
        repeat (3) step_rand(0, 0, 0);
        step(0, 1, 32'hF000_0960, 32'h0000_0042, 0);
        repeat (3) step_rand(0, 0, 0);

        // Saturating console traffic with the debugger always pending.
        dbg_pct = 100;
        for (int i = 0; i < 60; i++) step(0, 1, 32'hF000_0000 | 32'(i), 32'(i), 0);
        // Debugger alone against an empty FIFO.
        repeat (20) step_rand(0, 0, 0);

        // Clear re-requested mid-way, then reset at ptr=1000.
        dbg_pct = 30;
        step_rand(30, 0, 1);
        for (int i = 0; i < 1000; i++) step_rand(30, 0, i == 500);
        repeat (2) step_rand(30, 1, 0);

        // Full clear with sporadic re-requests, then long random mix.
        step_rand(40, 0, 1);
        for (int i = 0; i < 2410; i++) step_rand(40, 0, $urandom_range(0, 99) == 0);
        for (int i = 0; i < 1500; i++) begin
            dbg_pct = (i < 750) ? 60 : 20;
            step_rand((i < 750) ? 30 : 80, 0, 0);
        end
        repeat (10) step_rand(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
